spoof_check_scheduler: RTL
==========================

# spoof_check_scheduler

Time-shares one position-jump check datapath among NCH GPS receiver channels. A round-robin arbiter accepts one position sample at a time over per-channel valid/ready handshakes. Each sample is compared against that channel's stored last position. Consecutive jumps are counted per channel, and a sticky per-channel alert is raised until software acknowledges it. The block sits between the receiver front-ends and the navigation/security status registers.

## Interface
- NCH, 4, number of receiver channels (2..8)
- W, 32, position sample width
- THRESH, 200, jump threshold in position LSBs
- ALERT_COUNT, 3, consecutive jumps required to raise alert (1..15)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- pos_valid  in  NCH  per-channel sample valid
- pos_data  in  NCH*W  per-channel sample; channel i at bits [i*W +: W]
- pos_ready  out  NCH  one-hot grant; sample i transfers when pos_valid[i] && pos_ready[i]
- alert  out  NCH  sticky per-channel spoof alert
- alert_ack  in  NCH  clears the corresponding alert
- chk_done  out  1  one-cycle strobe: a check completed
- chk_ch  out  3  channel of the completed check (valid with chk_done)
- chk_jump  out  1  completed sample was a jump (valid with chk_done)
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, CHECK, UPDATE. Reset state is IDLE.
- IDLE:
  - If any pos_valid is set, select the first set channel at or after rr_ptr, in increasing index with wrap.
  - Assert pos_ready for that channel only, combinationally, in this cycle.
  - Capture pos_data into sample_q and the channel into ch_q.
  - Set rr_ptr = ch_q+1 mod NCH. Go to CHECK.
  - If no pos_valid is set, pos_ready = 0 and the FSM stays in IDLE.
- CHECK:
  - Compute jump = primed[ch_q] && (sample_q > last[ch_q] + THRESH).
  - The addition is W+1 bits wide, so it never wraps: last = 2^W-1 can never flag an upward jump.
  - Register jump_q. Go to UPDATE.
- UPDATE:
  - last[ch_q] <= sample_q; primed[ch_q] <= 1.
  - cnt[ch_q] <= jump_q ? min(cnt+1, ALERT_COUNT) : 0. The counter saturates.
  - If jump_q and cnt+1 >= ALERT_COUNT, set alert[ch_q].
  - Pulse chk_done with chk_ch = ch_q and chk_jump = jump_q. Return to IDLE.
- The first sample of a channel after reset only primes that channel and never counts as a jump.
- alert[i] is cleared by alert_ack[i] in any state. If a set and an ack for the same channel occur in the same cycle, the set wins.
- Channels not granted are stalled. A requester must hold pos_valid and pos_data stable until it is granted.

## Timing
- Reset values:
  - pos_ready = 0, alert = 0, chk_done = 0, chk_ch = 0, chk_jump = 0, busy = 0.
  - rr_ptr = 0; all last = 0, primed = 0, cnt = 0.
- Latency: grant in cycle T, chk_done in cycle T+2. Alert is visible in cycle T+3.
- Throughput: one sample per 3 cycles. pos_ready is never asserted while busy.
- Reset asserted mid-check aborts the check. No chk_done is issued, and all state returns to reset values within the same cycle.
- Fairness: with all channels continuously valid, the grant order is 0,1,…,NCH-1,0,… Each channel waits at most 3*(NCH-1) cycles.

## Configuration
- SPOOF_BIDIR_EN defined: CHECK also flags a downward jump, last[ch_q] > sample_q + THRESH, using a W+1-bit compare. jump is the OR of the upward and downward conditions.
- SPOOF_BIDIR_EN undefined: only upward jumps are flagged. Downward jumps are treated as normal samples and reset the counter.

## Test plan
- Reset, then ch0 sends 1000, 1100, 1300 -> three chk_done pulses, all with chk_jump = 0 (1300 is not > 1100+200). alert stays 0.
- ch1 sends 0, 500, 1000, 1500 with ALERT_COUNT=3 -> chk_jump pattern 0,1,1,1. alert[1] rises exactly 1 cycle after the 4th chk_done.
- ch2 sends 0, 500, 600, 1200 -> pattern 0,1,0,1. The counter resets on the non-jump, so alert[2] stays 0.
- All 4 channels hold pos_valid continuously -> pos_ready order is 0,1,2,3,0, with grants exactly 3 cycles apart and busy high between grants.
- alert[1] set, then alert_ack[1] is pulsed in the same cycle that a 3rd consecutive jump sets it -> alert[1] remains 1. A later ack alone -> alert[1] goes to 0.
- ch3 sends 5000 then 100: with SPOOF_BIDIR_EN, chk_jump = 1 on the 2nd sample; without it, chk_jump = 0. Separately, assert rst in CHECK -> no chk_done is issued and all outputs are 0.

Source files
------------

// File: rtl/spoof_check_scheduler.sv
// spoof_check_scheduler
//   Shares one position-jump check datapath among NCH GPS receiver channels.
//   A round-robin arbiter takes one sample at a time through per-channel
//   valid/ready handshakes. Each sample is compared against the channel's
//   previous position. Consecutive jumps are counted per channel, and a
//   sticky alert is raised once ALERT_COUNT jumps in a row have been seen.
//
//   Optional feature macro: SPOOF_BIDIR_EN. When it is defined, downward
//   jumps are flagged as well. In the default build only upward jumps count.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : asynchronous reset, active high
//   pos_valid  : per-channel sample valid
//   pos_data   : per-channel sample, channel i at bits [i*W +: W]
//   pos_ready  : one-hot grant, asserted combinationally in IDLE
//   alert      : sticky per-channel spoof alert
//   alert_ack  : per-channel alert clear (a same-cycle set wins)
//   chk_done   : one-cycle strobe, a check completed
//   chk_ch     : channel of the completed check
//   chk_jump   : the completed sample was a jump
//   busy       : scheduler is not idle
module spoof_check_scheduler #(
  parameter int NCH         = 4,
  parameter int W           = 32,
  parameter int THRESH      = 200,
  parameter int ALERT_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   pos_valid,
  input  logic [NCH*W-1:0] pos_data,
  output logic [NCH-1:0]   pos_ready,
  output logic [NCH-1:0]   alert,
  input  logic [NCH-1:0]   alert_ack,
  output logic             chk_done,
  output logic [2:0]       chk_ch,
  output logic             chk_jump,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;

  logic [2:0]     rr_ptr_r;
  logic [2:0]     ch_r;
  logic [W-1:0]   sample_r;
  logic           jump_r;
  logic [W-1:0]   last_r [NCH];
  logic [NCH-1:0] primed_r;
  logic [3:0]     cnt_r [NCH];

  logic [NCH-1:0] alert_r;
  logic           chk_done_r;
  logic [2:0]     chk_ch_r;
  logic           chk_jump_r;

  logic           grant_found_s;
  logic [2:0]     grant_ch_s;
  logic [3:0]     cand_s;
  logic           hit_s;
  logic [NCH-1:0] pos_ready_s;
  logic [W-1:0]   grant_data_s;
  logic [W-1:0]   last_sel_s;
  logic           primed_sel_s;
  logic [3:0]     cnt_sel_s;
  logic [W:0]     up_limit_s;
  logic           jump_s;
  logic [4:0]     cnt_inc_s;
  logic [3:0]     cnt_nxt_s;
  logic           alert_set_s;
`ifdef SPOOF_BIDIR_EN
  logic [W:0]     down_limit_s;
`endif

  // Round-robin search: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_ch_s    = 3'd0;
    cand_s        = 4'd0;
    hit_s         = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand_s = 4'(rr_ptr_r) + 4'(k);
      if (cand_s >= 4'(NCH)) begin
        cand_s = cand_s - 4'(NCH);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < NCH; j++) begin
        hit_s         = !grant_found_s && (cand_s == 4'(j)) && pos_valid[j];
        grant_ch_s    = hit_s ? 3'(j) : grant_ch_s;
        grant_found_s = grant_found_s | hit_s;
      end
    end
  end

  // AND-OR muxes: the granted input sample and the per-channel state of ch_r.
  always_comb begin
    grant_data_s = {W{1'b0}};
    last_sel_s   = {W{1'b0}};
    primed_sel_s = 1'b0;
    cnt_sel_s    = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      grant_data_s = grant_data_s | ({W{grant_ch_s == 3'(i)}} & pos_data[i*W +: W]);
      last_sel_s   = last_sel_s   | ({W{ch_r == 3'(i)}} & last_r[i]);
      primed_sel_s = primed_sel_s | ((ch_r == 3'(i)) & primed_r[i]);
      cnt_sel_s    = cnt_sel_s    | ({4{ch_r == 3'(i)}} & cnt_r[i]);
    end
  end

  // Jump compare, W+1 bits wide so that last + THRESH can never wrap.
  always_comb begin
    up_limit_s = {1'b0, last_sel_s} + (W+1)'(THRESH);
`ifdef SPOOF_BIDIR_EN
    down_limit_s = {1'b0, sample_r} + (W+1)'(THRESH);
    jump_s = primed_sel_s &&
             (({1'b0, sample_r} > up_limit_s) || ({1'b0, last_sel_s} > down_limit_s));
`else
    jump_s = primed_sel_s && ({1'b0, sample_r} > up_limit_s);
`endif
  end

  // Saturating consecutive-jump counter update and alert trigger.
  always_comb begin
    cnt_inc_s   = {1'b0, cnt_sel_s} + 5'd1;
    cnt_nxt_s   = 4'd0;
    alert_set_s = 1'b0;
    if (jump_r) begin
      cnt_nxt_s   = (cnt_inc_s > 5'(ALERT_COUNT)) ? 4'(ALERT_COUNT) : cnt_inc_s[3:0];
      alert_set_s = (state_r == ST_UPDATE) && (cnt_inc_s >= 5'(ALERT_COUNT));
    end else begin
      cnt_nxt_s   = 4'd0;
      alert_set_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and combinational grant (forced low while in reset).
  always_comb begin
    state_nxt_s = state_r;
    pos_ready_s = {NCH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
        for (int i = 0; i < NCH; i++) begin
          pos_ready_s[i] = !rst && grant_found_s && (grant_ch_s == 3'(i));
        end
      end
      ST_CHECK:  state_nxt_s = ST_UPDATE;
      ST_UPDATE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Sample capture, jump register and per-channel history update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= 3'd0;
      ch_r     <= 3'd0;
      sample_r <= {W{1'b0}};
      jump_r   <= 1'b0;
      primed_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        last_r[i] <= {W{1'b0}};
        cnt_r[i]  <= 4'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            sample_r <= grant_data_s;
            ch_r     <= grant_ch_s;
            rr_ptr_r <= (grant_ch_s == 3'(NCH-1)) ? 3'd0 : grant_ch_s + 3'd1;
          end
        end
        ST_CHECK: jump_r <= jump_s;
        ST_UPDATE: begin
          for (int i = 0; i < NCH; i++) begin
            if (ch_r == 3'(i)) begin
              last_r[i]   <= sample_r;
              primed_r[i] <= 1'b1;
              cnt_r[i]    <= cnt_nxt_s;
            end
          end
        end
        default: jump_r <= 1'b0;
      endcase
    end
  end

  // Completion strobe is loaded at the end of CHECK so it shows during UPDATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_done_r <= 1'b0;
      chk_ch_r   <= 3'd0;
      chk_jump_r <= 1'b0;
    end else begin
      chk_done_r <= (state_r == ST_CHECK);
      if (state_r == ST_CHECK) begin
        chk_ch_r   <= ch_r;
        chk_jump_r <= jump_s;
      end
    end
  end

  // Sticky alerts: a set in UPDATE takes priority over a same-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alert_r <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (alert_set_s && (ch_r == 3'(i))) begin
          alert_r[i] <= 1'b1;
        end else if (alert_ack[i]) begin
          alert_r[i] <= 1'b0;
        end
      end
    end
  end

  assign pos_ready = pos_ready_s;
  assign alert     = alert_r;
  assign chk_done  = chk_done_r;
  assign chk_ch    = chk_ch_r;
  assign chk_jump  = chk_jump_r;
  assign busy      = (state_r != ST_IDLE);

endmodule
